demux_1to_n_dispatch: RTL and testbench
=======================================

# demux_1to_n_dispatch

Registered 1-to-N demultiplexer that steers a 32-bit word stream to one of `NUM_OUT` destinations. It is the distribution counterpart of the datapath selector muxes: a producer presents a word plus a select code, and the block delivers it to the chosen consumer through a one-entry holding register with a valid/ready handshake. It sits between the cipher datapath output and its consumers: result registers, memory write port, and MMIO.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `NUM_OUT`, 6, number of destination channels (2..16)
- `SEL_W`, 4, select code width; must satisfy `NUM_OUT <= 2**SEL_W`

Ports:
- `CLK`  in  1  single clock; all state updates on the rising edge
- `RST`  in  1  reset; asynchronous and active-high
- `IN_DATA`  in  WIDTH  word to deliver
- `IN_SEL`  in  SEL_W  destination code
- `IN_VALID`  in  1  producer has a word
- `IN_READY`  out  1  block accepts the word this cycle
- `OUT_DATA`  out  NUM_OUT×WIDTH  per-channel held word
- `OUT_VALID`  out  NUM_OUT  per-channel word present
- `OUT_READY`  in  NUM_OUT  per-channel consumer accepts
- `SEL_ERR`  out  1  sticky flag: a word was accepted with an out-of-range `IN_SEL`
- `SEL_ERR_CLR`  in  1  synchronous clear of `SEL_ERR`
- `ACCEPT_CNT`  out  16  total words accepted; wraps modulo 2^16

## Operation
- Effective target `t` = `IN_SEL` if `IN_SEL < NUM_OUT`, else 0. This matches the mux convention: out-of-range selects channel 0.
- Each channel has a one-entry slot with two states. EMPTY has `OUT_VALID[i]`=0. FULL has `OUT_VALID[i]`=1.
- `IN_READY` = !`OUT_VALID[t]` || `OUT_READY[t]`. It is combinational from `IN_SEL`, `OUT_VALID` and `OUT_READY`, and is independent of `IN_VALID`.
- A word is accepted when `IN_VALID` && `IN_READY`. On acceptance, slot `t` loads `IN_DATA` and goes or stays FULL.
- Channel i drains when `OUT_VALID[i]` && `OUT_READY[i]`. If no accept targets i in the same cycle, the slot goes EMPTY.
- Simultaneous drain and accept on the same channel: the slot stays FULL with the new word. This gives full throughput of one word per cycle.
- While a slot is FULL and not drained, `OUT_DATA[i]` is stable.
- `OUT_DATA[i]` of an EMPTY slot holds its last value and is a don't-care for consumers.
- Drains on different channels are independent. Any subset may drain in one cycle.
- `SEL_ERR` sets on an accepted word with `IN_SEL >= NUM_OUT`. A non-accepted out-of-range request does not set it.
- If `SEL_ERR_CLR` and a new set event occur in the same cycle, set wins.
- `ACCEPT_CNT` increments by 1 per accepted word and wraps from 0xFFFF to 0x0000.
- An `IN_VALID` request that is not accepted may change `IN_SEL`/`IN_DATA` next cycle; no sticky requirement is imposed on the producer.

## Timing
- Reset values: all `OUT_VALID` 0, all `OUT_DATA` 0, `SEL_ERR` 0, `ACCEPT_CNT` 0. `IN_READY` is therefore 1 out of reset.
- Reset mid-operation discards all held words immediately (asynchronous). The first accept is possible on the first rising edge after `RST` deasserts.
- Latency: a word accepted at edge k is visible on `OUT_DATA[t]` with `OUT_VALID[t]`=1 after edge k. It can be consumed in cycle k+1.
- No combinational path from `IN_DATA` to `OUT_DATA`. All outputs except `IN_READY` are registered.
- `SEL_ERR` and `ACCEPT_CNT` update at the same edge as the accept.

## Structure
- Package `demux_pkg` holds:
  - constants `DEMUX_WIDTH_DEF`=32, `DEMUX_NUM_OUT_DEF`=6, `DEMUX_CNT_W`=16
  - function `eff_target(sel, num_out)` returning the effective channel index
- Sub-module `demux_out_slot`: one-entry register with load/drain inputs and valid/data outputs. It is instantiated `NUM_OUT` times via generate.
- The top level contains target decode, `IN_READY` logic, the error flag and the counter.

## Test plan
- After reset: `IN_SEL`=2, data 0xDEADBEEF, `IN_VALID`=1 for one cycle, all `OUT_READY`=0 → next cycle `OUT_VALID`=6'b000100, `OUT_DATA[2]`=0xDEADBEEF, `ACCEPT_CNT`=1.
- Backpressure: channel 2 FULL, `OUT_READY[2]`=0, request to ch 2 → `IN_READY`=0, data unchanged. Request to ch 3 the same cycle instead → accepted.
- Full throughput: `OUT_READY[1]`=1 held, 8 back-to-back words 0..7 to ch 1 → `IN_READY` stays 1 and ch 1 delivers 0..7 in order, one per cycle.
- Out-of-range: `IN_SEL`=9, data 0x12345678 → lands in ch 0 and `SEL_ERR`=1. Assert `SEL_ERR_CLR` with another `IN_SEL`=9 accept in the same cycle → `SEL_ERR` remains 1. A clear alone → 0.
- Counter wrap: preload by 65535 accepts, then one more → `ACCEPT_CNT`=0x0000.
- Reset mid-stream: 3 slots FULL, pulse `RST` between edges → all `OUT_VALID` 0 immediately, `OUT_DATA` 0, counter 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and target decode for the 1-to-N word dispatcher.
// Out-of-range codes fall back to channel 0, like the datapath muxes.
package demux_pkg;

  localparam int DEMUX_WIDTH_DEF   = 32;
  localparam int DEMUX_NUM_OUT_DEF = 6;
  localparam int DEMUX_CNT_W       = 16;

  function automatic int unsigned eff_target(
    input int unsigned sel,
    input int unsigned num_out
  );
    return (sel < num_out) ? sel : 32'd0;
  endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry holding register for a single destination channel.
// A load in the same cycle as a drain keeps the slot full with new data.
module demux_out_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEMUX_WIDTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             drain_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux_1to_n_dispatch.sv
// Registered 1-to-N demultiplexer with per-channel valid/ready slots,
// a sticky bad-select flag and a wrapping accept counter.
module demux_1to_n_dispatch
  import demux_pkg::*;
#(
  parameter int WIDTH   = DEMUX_WIDTH_DEF,
  parameter int NUM_OUT = DEMUX_NUM_OUT_DEF,
  parameter int SEL_W   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         IN_DATA,
  input  logic [SEL_W-1:0]         IN_SEL,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [NUM_OUT*WIDTH-1:0] OUT_DATA,
  output logic [NUM_OUT-1:0]       OUT_VALID,
  input  logic [NUM_OUT-1:0]       OUT_READY,
  output logic                     SEL_ERR,
  input  logic                     SEL_ERR_CLR,
  output logic [DEMUX_CNT_W-1:0]   ACCEPT_CNT
);

  int unsigned              tgt;
  logic [NUM_OUT-1:0]       hit;
  logic                     accept;
  logic                     oor;
  logic                     sel_err_q, sel_err_d;
  logic [DEMUX_CNT_W-1:0]   cnt_q, cnt_d;

  assign tgt = eff_target(32'(IN_SEL), NUM_OUT);
  assign oor = 32'(IN_SEL) >= NUM_OUT;

  // One-hot target; ready is the target slot's free-or-draining state.
  assign IN_READY = |(hit & (~OUT_VALID | OUT_READY));
  assign accept   = IN_VALID && IN_READY;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_slot
    assign hit[i] = (tgt == i);
    demux_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i   (CLK),
      .rst_i   (RST),
      .load_i  (accept && hit[i]),
      .drain_i (OUT_VALID[i] && OUT_READY[i]),
      .data_i  (IN_DATA),
      .valid_o (OUT_VALID[i]),
      .data_o  (OUT_DATA[i*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    sel_err_d = sel_err_q;
    cnt_d     = cnt_q;
    if (accept && oor) begin
      sel_err_d = 1'b1;
    end else if (SEL_ERR_CLR) begin
      sel_err_d = 1'b0;
    end
    if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sel_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sel_err_q <= sel_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign SEL_ERR    = sel_err_q;
  assign ACCEPT_CNT = cnt_q;

endmodule

// File: tb/tb_demux_1to_n_dispatch.sv
// Directed plus random checks of the dispatcher against a slot-array model.
// Inputs change just after a rising edge; outputs are sampled 1ns later.
module tb_demux_1to_n_dispatch;

  localparam int N = 6;
  localparam int W = 32;

  logic            CLK;
  logic            RST;
  logic [W-1:0]    IN_DATA;
  logic [3:0]      IN_SEL;
  logic            IN_VALID;
  logic            IN_READY;
  logic [N*W-1:0]  OUT_DATA;
  logic [N-1:0]    OUT_VALID;
  logic [N-1:0]    OUT_READY;
  logic            SEL_ERR;
  logic            SEL_ERR_CLR;
  logic [15:0]     ACCEPT_CNT;

  demux_1to_n_dispatch dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_DATA     (IN_DATA),
    .IN_SEL      (IN_SEL),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .OUT_DATA    (OUT_DATA),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .SEL_ERR     (SEL_ERR),
    .SEL_ERR_CLR (SEL_ERR_CLR),
    .ACCEPT_CNT  (ACCEPT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_data [N];
  bit           m_valid [N];
  bit           m_err;
  logic [15:0]  m_cnt;
  logic         last_rdy;

  task automatic check(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i]  = '0;
      m_valid[i] = 1'b0;
    end
    m_err = 1'b0;
    m_cnt = '0;
  endtask

  task automatic check_outputs();
    logic [N*W-1:0] ed;
    logic [N-1:0]   ev;
    for (int i = 0; i < N; i++) begin
      ed[i*W +: W] = m_data[i];
      ev[i]        = m_valid[i];
    end
    check("out_valid", 256'(OUT_VALID), 256'(ev));
    check("out_data", 256'(OUT_DATA), 256'(ed));
    check("sel_err", 256'(SEL_ERR), 256'(m_err));
    check("accept_cnt", 256'(ACCEPT_CNT), 256'(m_cnt));
  endtask

  // One clock cycle: drive, check ready, clock, update model, check outputs.
  task automatic step(input logic [W-1:0] d, input logic [3:0] s,
                      input logic v, input logic [N-1:0] r,
                      input logic clr);
    int  t;
    bit  rdy;
    bit  acc;
    IN_DATA     = d;
    IN_SEL      = s;
    IN_VALID    = v;
    OUT_READY   = r;
    SEL_ERR_CLR = clr;
    #1;
    t   = (int'(s) < N) ? int'(s) : 0;
    rdy = !m_valid[t] || r[t];
    acc = v && rdy;
    last_rdy = rdy;
    check("in_ready", 256'(IN_READY), 256'(rdy));
    @(posedge CLK);
    for (int i = 0; i < N; i++)
      if (m_valid[i] && r[i]) m_valid[i] = 1'b0;
    if (acc) begin
      m_valid[t] = 1'b1;
      m_data[t]  = d;
      m_cnt      = m_cnt + 16'd1;
    end
    if (acc && int'(s) >= N) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    #1;
    check_outputs();
  endtask

  initial begin
    RST = 1'b1;
    IN_DATA = '0;
    IN_SEL = '0;
    IN_VALID = 1'b0;
    OUT_READY = '0;
    SEL_ERR_CLR = 1'b0;
    last_rdy = 1'b0;
    model_reset();
    #12;
    RST = 1'b0;
    #1;
    check_outputs();
    check("reset_in_ready", 256'(IN_READY), 256'(1));

    // Single word to channel 2
    step(32'hDEADBEEF, 4'd2, 1'b1, 6'b0, 1'b0);
    check("t1_valid", 256'(OUT_VALID), 256'(6'b000100));
    check("t1_data2", 256'(OUT_DATA[2*W +: W]), 256'(32'hDEADBEEF));
    check("t1_cnt", 256'(ACCEPT_CNT), 256'(16'd1));

    // Backpressure on ch 2, then ch 3 accepted
    step(32'h11111111, 4'd2, 1'b1, 6'b0, 1'b0);
    check("bp_ready", 256'(last_rdy), 256'(0));
    check("bp_data2", 256'(OUT_DATA[2*W +: W]), 256'(32'hDEADBEEF));
    step(32'h33333333, 4'd3, 1'b1, 6'b0, 1'b0);
    check("bp_ch3", 256'(OUT_DATA[3*W +: W]), 256'(32'h33333333));

    // Full throughput on ch 1
    for (int k = 0; k < 8; k++) begin
      step(32'(k), 4'd1, 1'b1, 6'b000010, 1'b0);
      check("tp_ready", 256'(last_rdy), 256'(1));
      check("tp_data1", 256'(OUT_DATA[1*W +: W]), 256'(k));
    end
    step('0, 4'd0, 1'b0, 6'b000010, 1'b0);

    // Out-of-range select
    step(32'h12345678, 4'd9, 1'b1, 6'b0, 1'b0);
    check("oor_data0", 256'(OUT_DATA[W-1:0]), 256'(32'h12345678));
    check("oor_err", 256'(SEL_ERR), 256'(1));
    step(32'h9ABCDEF0, 4'd9, 1'b1, 6'b000001, 1'b1);
    check("oor_setwins", 256'(SEL_ERR), 256'(1));
    step('0, 4'd0, 1'b0, 6'b0, 1'b1);
    check("oor_clr", 256'(SEL_ERR), 256'(0));

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom, 4'($urandom_range(0, 15)), 1'($urandom),
           6'($urandom), 1'($urandom_range(0, 7) == 0));
    end

    // Counter wrap
    while (m_cnt != 16'hFFFF)
      step($urandom, 4'd0, 1'b1, 6'h3F, 1'b0);
    step(32'hCAFEF00D, 4'd0, 1'b1, 6'h3F, 1'b0);
    check("wrap_cnt", 256'(ACCEPT_CNT), 256'(16'h0000));

    // Asynchronous reset mid-stream
    step(32'hA, 4'd0, 1'b1, 6'b0, 1'b0);
    step(32'hB, 4'd4, 1'b1, 6'b0, 1'b0);
    step(32'hC, 4'd5, 1'b1, 6'b0, 1'b0);
    #2;
    RST = 1'b1;
    #1;
    check("rst_valid", 256'(OUT_VALID), 256'(0));
    check("rst_data", 256'(OUT_DATA), 256'(0));
    check("rst_cnt", 256'(ACCEPT_CNT), 256'(0));
    #1;
    RST = 1'b0;
    model_reset();
    step(32'h55AA55AA, 4'd4, 1'b1, 6'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
